operand_loader: RTL and testbench

- Upstream feeder for the 32-bit adder stage (a + b -> c).
- Receives a byte-wide valid/ready stream and assembles two DATA_WIDTH operands, A then B, each little-endian.
- Presents A and B together on a held-stable valid/ready output so the adder sees both operands change at once.
- Bridges the narrow external input path to the wide adder inputs.

---
 rtl/operand_loader_pkg.sv | 22 ++
 rtl/operand_loader_byte_lane_writer.sv | 32 +++
 rtl/operand_loader.sv | 111 +++++++++++
 tb/tb_operand_loader.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/operand_loader_pkg.sv
// Shared types and sizing helpers for the operand loader.
package operand_loader_pkg;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    PRESENT = 2'd2
  } state_t;

  function automatic int unsigned calc_nbytes(input int unsigned dw, input int unsigned bw);
    return dw / bw;
  endfunction

  function automatic int unsigned calc_cnt_w(input int unsigned nbytes);
    return $clog2(2 * nbytes) + 1;
  endfunction

  function automatic int unsigned calc_idx_w(input int unsigned nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/operand_loader_byte_lane_writer.sv
// Wide register written one byte lane at a time, with synchronous clear.
module byte_lane_writer
  import operand_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8
) (
  input  logic                                                  clock,
  input  logic                                                  reset_n,
  input  logic                                                  clear,
  input  logic                                                  we,
  input  logic [calc_idx_w(calc_nbytes(DATA_WIDTH, BYTE_WIDTH))-1:0] idx,
  input  logic [BYTE_WIDTH-1:0]                                 din,
  output logic [DATA_WIDTH-1:0]                                 q
);

  localparam int unsigned NBYTES = calc_nbytes(DATA_WIDTH, BYTE_WIDTH);
  localparam int unsigned IDX_W  = calc_idx_w(NBYTES);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (we) begin
      for (int unsigned k = 0; k < NBYTES; k++) begin
        if (idx == IDX_W'(k)) q[k*BYTE_WIDTH +: BYTE_WIDTH] <= din;
      end
    end
  end

endmodule

// File: rtl/operand_loader.sv
// Assembles two little-endian operands from a byte stream and presents them
// together to the adder on a valid/ready handshake.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [BYTE_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   abort,
  output logic [DATA_WIDTH-1:0]  out_a,
  output logic [DATA_WIDTH-1:0]  out_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [calc_cnt_w(calc_nbytes(DATA_WIDTH, BYTE_WIDTH))-1:0] byte_count
);

  localparam int unsigned NBYTES = calc_nbytes(DATA_WIDTH, BYTE_WIDTH);
  localparam int unsigned CW     = calc_cnt_w(NBYTES);
  localparam int unsigned IDX_W  = calc_idx_w(NBYTES);
  localparam logic [CW-1:0] LAST_A = CW'(NBYTES - 1);
  localparam logic [CW-1:0] LAST_B = CW'(2 * NBYTES - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_b;
  logic          valid_nx;
  logic          we_a, we_b, clr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= LOAD_A;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      out_valid <= valid_nx;
    end
  end

  // in_ready depends on registered state only, so accepting never waits on out_ready
  assign in_ready   = (state != PRESENT);
  assign byte_count = cnt;
  assign cnt_b      = cnt - CW'(NBYTES);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    valid_nx = out_valid;
    we_a     = 1'b0;
    we_b     = 1'b0;
    clr      = 1'b0;
    if (abort) begin
      state_nx = LOAD_A;
      cnt_nx   = '0;
      valid_nx = 1'b0;
      clr      = 1'b1;
    end else begin
      case (state)
        LOAD_A: if (in_valid) begin
          we_a   = 1'b1;
          cnt_nx = cnt + 1'b1;
          if (cnt == LAST_A) state_nx = LOAD_B;
        end
        LOAD_B: if (in_valid) begin
          we_b   = 1'b1;
          cnt_nx = cnt + 1'b1;
          if (cnt == LAST_B) begin
            state_nx = PRESENT;
            valid_nx = 1'b1;
          end
        end
        PRESENT: if (out_valid && out_ready) begin
          state_nx = LOAD_A;
          cnt_nx   = '0;
          valid_nx = 1'b0;
        end
        default: begin
          state_nx = LOAD_A;
          cnt_nx   = '0;
          valid_nx = 1'b0;
        end
      endcase
    end
  end

  byte_lane_writer #(.DATA_WIDTH(DATA_WIDTH), .BYTE_WIDTH(BYTE_WIDTH)) u_lane_a (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clr),
    .we      (we_a),
    .idx     (cnt[IDX_W-1:0]),
    .din     (in_data),
    .q       (out_a)
  );

  byte_lane_writer #(.DATA_WIDTH(DATA_WIDTH), .BYTE_WIDTH(BYTE_WIDTH)) u_lane_b (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clr),
    .we      (we_b),
    .idx     (cnt_b[IDX_W-1:0]),
    .din     (in_data),
    .q       (out_b)
  );

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader: expected pairs queued at stimulus time,
// compared when the output handshake fires.
module tb_operand_loader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        abort = 1'b0;
  logic [31:0] out_a, out_b;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  byte_count;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  logic [63:0] exp_q[$];
  int unsigned hs_q[$];
  bit          b2b = 1'b0;

  operand_loader #(.DATA_WIDTH(32), .BYTE_WIDTH(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .abort      (abort),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .byte_count (byte_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Handshake monitor: pops the scoreboard at every consumed pair.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_pair", 64'(exp_q.size()), 64'd1);
      else check("pair", {out_b, out_a}, exp_q.pop_front());
      if (b2b) hs_q.push_back(cyc);
    end
  end

  task automatic send_byte(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clock);
      ok = in_ready;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_pair(input logic [31:0] a, input logic [31:0] b, input int unsigned gap);
    for (int unsigned k = 0; k < 4; k++) begin
      send_byte(a[k*8 +: 8]);
      repeat (gap) begin @(posedge clock); #1; end
    end
    for (int unsigned k = 0; k < 4; k++) begin
      send_byte(b[k*8 +: 8]);
      repeat (gap) begin @(posedge clock); #1; end
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_ab", {out_b, out_a}, 64'd0);
    check("rst_count", 64'(byte_count), 64'd0);
    @(posedge clock); #1;

    // basic load, out_ready held low
    exp_q.push_back({32'h0000_0001, 32'h1234_5678});
    send_pair(32'h1234_5678, 32'h0000_0001, 0);
    @(negedge clock);
    check("basic_valid", 64'(out_valid), 64'd1);
    check("basic_a", 64'(out_a), 64'h1234_5678);
    check("basic_b", 64'(out_b), 64'h0000_0001);
    check("basic_in_ready", 64'(in_ready), 64'd0);
    check("basic_count", 64'(byte_count), 64'd8);
    @(posedge clock); #1;

    // backpressure: FF bytes offered but not accepted
    in_valid = 1'b1;
    in_data  = 8'hFF;
    repeat (20) begin @(posedge clock); #1; end
    @(negedge clock);
    check("bp_ab", {out_b, out_a}, {32'h0000_0001, 32'h1234_5678});
    check("bp_count", 64'(byte_count), 64'd8);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    @(posedge clock); #1;
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clock);
    check("post_hs_in_ready", 64'(in_ready), 64'd1);
    check("post_hs_count", 64'(byte_count), 64'd0);
    check("post_hs_valid", 64'(out_valid), 64'd0);
    check("post_hs_retain_a", 64'(out_a), 64'h1234_5678);
    @(posedge clock); #1;

    // input gaps
    exp_q.push_back({32'hFFFF_FFFF, 32'hDEAD_BEEF});
    send_pair(32'hDEAD_BEEF, 32'hFFFF_FFFF, 3);
    @(negedge clock);
    check("gap_sum", 64'(32'(out_a + out_b)), 64'hDEAD_BEEE);
    @(posedge clock); #1;
    handshake();

    // abort mid-B with a byte offered in the abort cycle
    for (int unsigned k = 0; k < 6; k++) send_byte(8'(8'h11 * (k + 1)));
    in_valid = 1'b1;
    in_data  = 8'h77;
    abort    = 1'b1;
    @(posedge clock); #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    check("abort_count", 64'(byte_count), 64'd0);
    check("abort_ab", {out_b, out_a}, 64'd0);
    check("abort_valid", 64'(out_valid), 64'd0);
    @(posedge clock); #1;
    exp_q.push_back({32'hB4B3_B2B1, 32'hA4A3_A2A1});
    send_pair(32'hA4A3_A2A1, 32'hB4B3_B2B1, 0);
    @(negedge clock);
    check("post_abort_count", 64'(byte_count), 64'd8);
    @(posedge clock); #1;
    handshake();

    // async reset between edges during LOAD_B
    for (int unsigned k = 0; k < 5; k++) send_byte(8'h5A);
    #1 reset_n = 1'b0;
    #1;
    check("arst_ab", {out_b, out_a}, 64'd0);
    check("arst_count", 64'(byte_count), 64'd0);
    check("arst_valid", 64'(out_valid), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_count_rel", 64'(byte_count), 64'd0);

    // back-to-back with out_ready tied high
    b2b = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back({32'h0BAD_F00D, 32'hCAFE_BABE});
    exp_q.push_back({32'h8765_4321, 32'h1357_9BDF});
    send_pair(32'hCAFE_BABE, 32'h0BAD_F00D, 0);
    send_pair(32'h1357_9BDF, 32'h8765_4321, 0);
    for (int i = 0; i < 40 && hs_q.size() < 2; i++) @(posedge clock);
    check("b2b_pulses", 64'(hs_q.size()), 64'd2);
    if (hs_q.size() >= 2) check("b2b_spacing", 64'(hs_q[1] - hs_q[0]), 64'd9);
    out_ready = 1'b0;
    @(negedge clock);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
